// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// Adds ovf when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first: one full-adder slice with b inverted and carry-in 1.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the lower WIDTH-1 result bits; the final bit is merged straight into diff.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             nb, s, cout;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    nb   = ~b_sr_q[0];
    s    = a_sr_q[0] ^ nb ^ carry_q;
    cout = (a_sr_q[0] & nb) | (a_sr_q[0] & carry_q) | (nb & carry_q);

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = StShift;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = 1'b1;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
        end
      end
      StShift: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = (WIDTH-1)'({s, res_q} >> 1);
        carry_d = cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d  = StDone;
          diff_d   = {s, res_q};
          borrow_d = ~cout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (s ^ a_msb_q);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == StShift);
  assign bus.done   = (state_q == StDone);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor; expected results come from plain arithmetic.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  logic [W-1:0] held_diff;
  logic         held_borrow;
  logic         held_ovf;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call just after a negedge; the next posedge is the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // Follows one operation from the first busy cycle to the done cycle.
  task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int sa, sb, sd;
    logic [W-1:0] ed;
    logic eb, eo;
    ed = W'(int'(a) - int'(b));
    eb = (a < b);
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    sd = sa - sb;
    eo = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      chk("busy", 32'(bus.busy), 32'd1);
      chk("done_early", 32'(bus.done), 32'd0);
      chk("diff_held", 32'(bus.diff), 32'(held_diff));
      chk("borrow_held", 32'(bus.borrow), 32'(held_borrow));
      if (poke && k == 2) begin
        bus.start = 1'b1;
        bus.a     = 1;
        bus.b     = 1;
      end
      if (poke && k == 3) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("done", 32'(bus.done), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("borrow", 32'(bus.borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(bus.ovf), 32'(eo));
`endif
    held_diff   = ed;
    held_borrow = eb;
    held_ovf    = eo;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    held_diff   = '0;
    held_borrow = 1'b0;
    held_ovf    = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    idle_check();
    issue(8'd20, 8'd7);
    run_check(8'd20, 8'd7, 1'b0);
    idle_check();
    issue(8'd7, 8'd20);
    run_check(8'd7, 8'd20, 1'b0);
    idle_check();

    // Back-to-back: second start issued in the done cycle.
    issue(8'hA5, 8'hA5);
    run_check(8'hA5, 8'hA5, 1'b0);
    issue(8'd0, 8'd1);
    run_check(8'd0, 8'd1, 1'b0);
    idle_check();

    issue(8'd50, 8'd10);
    run_check(8'd50, 8'd10, 1'b1);
    idle_check();

    // Reset in the fourth shift cycle aborts with no done pulse.
    issue(8'd9, 8'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_borrow", 32'(bus.borrow), 32'd0);
    held_diff   = '0;
    held_borrow = 1'b0;
    held_ovf    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(W) + 2; k++) idle_check();
    issue(8'd9, 8'd3);
    run_check(8'd9, 8'd3, 1'b0);
    idle_check();

`ifdef SERIAL_SUB_OVF_EN
    issue(8'h80, 8'h01);
    run_check(8'h80, 8'h01, 1'b0);
    issue(8'h05, 8'h03);
    run_check(8'h05, 8'h03, 1'b0);
    idle_check();
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(1, 0) == 0) idle_check();
      issue(ra, rb);
      run_check(ra, rb, 1'($urandom_range(1, 0)));
    end
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor computing diff = a - b one bit per clock, LSB first.
It is the inverse arithmetic path to the team's 1-bit full adder cell. The datapath is one full-adder slice with b inverted, carry-in forced to 1 on the first bit, and a registered carry between bits.
It sits behind a simple start/done handshake so a controller can issue WIDTH-bit subtractions without a parallel borrow chain.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when idle or done
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; diff and borrow are valid
diff  output  WIDTH  result a - b modulo 2^WIDTH
borrow  output  1  1 when a < b (unsigned); equals inverted final carry

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, diff=0, borrow=0; internal shift registers, carry and bit counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge N captures a and b into shift regs, loads carry=1, clears counter, goes to SHIFT. busy=1 from cycle N+1.
- SHIFT: each edge computes s = a_sr[0] ^ ~b_sr[0] ^ carry and next carry = majority(a_sr[0], ~b_sr[0], carry).
  - s shifts into the result MSB; a_sr and b_sr shift right; counter increments.
  - After the WIDTH-th bit (edge N+WIDTH): go to DONE, busy=0, done=1, diff=result, borrow=~carry_out.
- Latency: done is high in the cycle following edge N+WIDTH, i.e. WIDTH clocks after the accept edge. Throughput is one operation per WIDTH+1 cycles.
- DONE: lasts exactly one cycle and returns to IDLE. If start=1 in DONE, the new operands are accepted exactly as from IDLE (back-to-back, no idle bubble).
- diff and borrow hold their last values until the next DONE. They do not change during SHIFT.
- start while busy=1 is ignored; operands are not recaptured.
- a and b may change freely after the accept edge.
- Reset mid-SHIFT aborts the operation immediately; no done pulse is generated.
- Counter width is clog2(WIDTH)+1; it never wraps during a valid operation.
- busy and done are never high together.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output ovf (1 bit). ovf is the two's-complement signed overflow of a - b, computed as a[MSB] != b[MSB] and diff[MSB] != a[MSB] using the captured operand MSBs. It is valid with done, held like diff, and reset to 0.
- Undefined: port ovf is absent; no extra logic is present. All other behaviour is identical.

Test Plan:
1. WIDTH=8, a=20, b=7, start one cycle -> done exactly 8 cycles after the accept edge; diff=13, borrow=0; busy high for 8 cycles.
2. a=7, b=20 -> diff=8'hF3 (243), borrow=1.
3. a=8'hA5, b=8'hA5, then a back-to-back start in the DONE cycle with a=0, b=1 -> first result diff=0, borrow=0; second result diff=8'hFF, borrow=1 with no idle cycle between operations.
4. Start a=50, b=10, then pulse start with a=1, b=1 while busy -> second request is ignored; diff=40.
5. Start a=9, b=3, assert rst in the 4th SHIFT cycle -> all outputs 0 immediately, no done pulse. A new start a=9, b=3 afterwards -> diff=6.
6. With SERIAL_SUB_OVF_EN defined: a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1. Then a=8'h05, b=8'h03 -> diff=8'h02, ovf=0.
